// File: rtl/tmds_channel_encoder.sv
// Single-channel TMDS encoder: 8b/10b video with DC balance, control and guard codes, 2-clock latency.
// Optional TERC4 data-island mode is compiled in with `define TMDS_ENC_TERC4_EN.
module tmds_channel_encoder #(
   parameter int CHANNEL = 0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] data_i,
   input  logic [1:0] ctrl_i,
   input  logic       de_i,
   input  logic       guard_i,
`ifdef TMDS_ENC_TERC4_EN
   input  logic       island_i,
   input  logic [3:0] aux_i,
`endif
   output logic [9:0] tmds_o
);

   // No handshake: one symbol is accepted and one produced every clock, fixed 2-clock latency.
   typedef enum logic [1:0] {
      MODE_CTRL,
      MODE_VIDEO,
      MODE_GUARD,
      MODE_ISLAND
   } mode_e;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

`ifdef TMDS_ENC_TERC4_EN
   function automatic logic [9:0] terc4_code(input logic [3:0] a);
      logic [9:0] c;
      case (a)
         4'h0: c = 10'h29C;
         4'h1: c = 10'h263;
         4'h2: c = 10'h2E4;
         4'h3: c = 10'h2E2;
         4'h4: c = 10'h171;
         4'h5: c = 10'h11E;
         4'h6: c = 10'h18E;
         4'h7: c = 10'h13C;
         4'h8: c = 10'h2CC;
         4'h9: c = 10'h139;
         4'hA: c = 10'h19C;
         4'hB: c = 10'h2C6;
         4'hC: c = 10'h28E;
         4'hD: c = 10'h271;
         4'hE: c = 10'h163;
         default: c = 10'h2C3;
      endcase
      return c;
   endfunction
`endif

   localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

   // Stage 1: mode decode and transition minimisation
   logic [3:0] n1_in;
   logic       use_xnor;
   logic [8:0] q_m_d;
   mode_e      mode_d;

   always_comb begin
      n1_in    = popcount8(data_i);
      use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !data_i[0]);
      q_m_d    = '0;
      q_m_d[0] = data_i[0];
      for (int i = 1; i < 8; i++)
         q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data_i[i]) : (q_m_d[i-1] ^ data_i[i]);
      q_m_d[8] = ~use_xnor;

      mode_d = MODE_CTRL;
`ifdef TMDS_ENC_TERC4_EN
      if (island_i) mode_d = MODE_ISLAND;
`endif
      if (guard_i) mode_d = MODE_GUARD;
      if (de_i)    mode_d = MODE_VIDEO;
   end

   mode_e      mode_q;
   logic [1:0] ctrl_q;
   logic [8:0] q_m_q;
`ifdef TMDS_ENC_TERC4_EN
   logic [3:0] aux_q;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_q <= MODE_CTRL;
         ctrl_q <= 2'b00;
         q_m_q  <= '0;
`ifdef TMDS_ENC_TERC4_EN
         aux_q  <= '0;
`endif
      end else begin
         mode_q <= mode_d;
         ctrl_q <= ctrl_i;
         q_m_q  <= q_m_d;
`ifdef TMDS_ENC_TERC4_EN
         aux_q  <= aux_i;
`endif
      end
   end

   // Stage 2: DC balance; disp = n1 - n0 of q_m[7:0], range -8..+8
   logic signed [4:0] cnt_q;
   logic signed [4:0] cnt_d;
   logic signed [4:0] disp;
   logic signed [5:0] disp_wide;
   logic signed [4:0] bias_one;
   logic signed [4:0] bias_zero;
   logic [9:0]        tmds_d;

   always_comb begin
      disp_wide = $signed({1'b0, popcount8(q_m_q[7:0]), 1'b0}) - 6'sd8;
      disp      = disp_wide[4:0];
      bias_one  = q_m_q[8] ? 5'sd2 : 5'sd0;
      bias_zero = q_m_q[8] ? 5'sd0 : 5'sd2;
      tmds_d    = 10'h354;
      cnt_d     = 5'sd0;
      case (mode_q)
         MODE_VIDEO: begin
            if ((cnt_q == 5'sd0) || (disp == 5'sd0)) begin
               tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
               cnt_d  = q_m_q[8] ? (cnt_q + disp) : (cnt_q - disp);
            end else if ((cnt_q > 5'sd0 && disp > 5'sd0) || (cnt_q < 5'sd0 && disp < 5'sd0)) begin
               tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
               cnt_d  = cnt_q + bias_one - disp;
            end else begin
               tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
               cnt_d  = cnt_q - bias_zero + disp;
            end
         end
         MODE_GUARD: tmds_d = GUARD_CODE;
`ifdef TMDS_ENC_TERC4_EN
         MODE_ISLAND: tmds_d = terc4_code(aux_q);
`endif
         default: begin
            case (ctrl_q)
               2'b00:   tmds_d = 10'h354;
               2'b01:   tmds_d = 10'h0AB;
               2'b10:   tmds_d = 10'h154;
               default: tmds_d = 10'h2AB;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmds_o <= 10'h354;
         cnt_q  <= 5'sd0;
      end else begin
         tmds_o <= tmds_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder (CHANNEL=1): directed vectors with hand-computed symbols,
// a short random video run against a reference model, and an expected-symbol queue.
module tb_tmds_channel_encoder;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic [7:0] data_i = '0;
   logic [1:0] ctrl_i = '0;
   logic       de_i = 1'b0;
   logic       guard_i = 1'b0;
`ifdef TMDS_ENC_TERC4_EN
   logic       island_i = 1'b0;
   logic [3:0] aux_i = '0;
`endif
   logic [9:0] tmds_o;

   always #5 clk_i = ~clk_i;

   tmds_channel_encoder #(.CHANNEL(1)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (data_i),
      .ctrl_i  (ctrl_i),
      .de_i    (de_i),
      .guard_i (guard_i),
`ifdef TMDS_ENC_TERC4_EN
      .island_i(island_i),
      .aux_i   (aux_i),
`endif
      .tmds_o  (tmds_o)
   );

   logic [9:0] exp_q[$];
   logic [8:0] vid_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         model_cnt = 0;
   int         run_disp = 0;
   logic       issue = 1'b0;
   logic       iss_d1, iss_d2;

   // Issue flag delayed by the 2-clock encoder latency marks which outputs to check.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iss_d1 <= 1'b0;
         iss_d2 <= 1'b0;
      end else begin
         iss_d1 <= issue;
         iss_d2 <= iss_d1;
      end
   end

   task automatic check_sym(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected within %0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   function automatic logic [9:0] model_video(input logic [7:0] d);
      int         ones, n1, n0;
      logic       xn;
      logic [8:0] qm;
      logic [9:0] sym;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      if (model_cnt == 0 || n1 == n0) begin
         sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         model_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
         sym = {1'b1, qm[8], ~qm[7:0]};
         model_cnt += 2 * int'(qm[8]) + n0 - n1;
      end else begin
         sym = {1'b0, qm[8], qm[7:0]};
         model_cnt += -2 * int'(!qm[8]) + n1 - n0;
      end
      return sym;
   endfunction

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] t[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
      return t[c];
   endfunction

   // Monitor: pops one expected symbol for every issued input, two clocks later.
   always @(negedge clk_i) begin
      if (iss_d2) begin
         if (exp_q.size() == 0) begin
            check_range("queue_underflow", 0, 1, 1);
         end else begin
            logic [9:0] e;
            logic [8:0] v;
            e = exp_q.pop_front();
            v = vid_q.pop_front();
            check_sym("symbol", tmds_o, e);
            if (v[8]) begin
               run_disp += 2 * $countones(tmds_o) - 10;
               check_range("running_disparity", run_disp, -10, 10);
               check_sym("decode", {2'b00, decode(tmds_o)}, {2'b00, v[7:0]});
            end else begin
               run_disp = 0;
            end
         end
      end
   end

   task automatic send_raw(input logic d_de, input logic g, input logic [1:0] c,
                           input logic [7:0] d, input logic [9:0] e);
      @(negedge clk_i);
      de_i = d_de;
      guard_i = g;
      ctrl_i = c;
      data_i = d;
      if (!d_de) model_cnt = 0;
      exp_q.push_back(e);
      vid_q.push_back({d_de, d});
      issue = 1'b1;
   endtask

   task automatic send_video_model(input logic [7:0] d);
      logic [9:0] e;
      e = model_video(d);
      send_raw(1'b1, 1'b0, 2'b00, d, e);
   endtask

   task automatic send_idle();
      @(negedge clk_i);
      de_i = 1'b0;
      guard_i = 1'b0;
      ctrl_i = 2'b00;
      issue = 1'b0;
   endtask

`ifdef TMDS_ENC_TERC4_EN
   logic [9:0] terc4_tbl[16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
                                 10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3};
`endif

   initial begin
      #1 rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check_sym("reset_value", tmds_o, 10'h354);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Control codes back to back
      send_raw(1'b0, 1'b0, 2'b00, 8'h00, 10'h354);
      send_raw(1'b0, 1'b0, 2'b01, 8'h00, 10'h0AB);
      send_raw(1'b0, 1'b0, 2'b10, 8'h00, 10'h154);
      send_raw(1'b0, 1'b0, 2'b11, 8'h00, 10'h2AB);

      // Disparity sequence from a balanced start: cnt -8, +2, -6
      send_raw(1'b1, 1'b0, 2'b00, 8'h00, 10'h100);
      send_raw(1'b1, 1'b0, 2'b00, 8'h00, 10'h3FF);
      send_raw(1'b1, 1'b0, 2'b00, 8'h00, 10'h100);
      // de falls: control follows, then video restarts with cnt cleared
      send_raw(1'b0, 1'b0, 2'b01, 8'h00, 10'h0AB);
      send_raw(1'b1, 1'b0, 2'b00, 8'h00, 10'h100);

      // Guard band and priority of video over guard
      send_raw(1'b0, 1'b1, 2'b00, 8'h00, 10'h133);
      send_raw(1'b1, 1'b1, 2'b00, 8'h00, 10'h100);
      send_raw(1'b0, 1'b0, 2'b00, 8'h00, 10'h354);
      send_raw(1'b1, 1'b0, 2'b00, 8'hFF, 10'h200);
      send_raw(1'b0, 1'b0, 2'b10, 8'h00, 10'h154);
      send_raw(1'b1, 1'b0, 2'b00, 8'h55, 10'h133);
      send_raw(1'b0, 1'b0, 2'b00, 8'h00, 10'h354);

      // Short random video runs with blanking
      for (int run = 0; run < 3; run++) begin
         for (int p = 0; p < 120; p++) send_video_model(8'($urandom_range(0, 255)));
         for (int b = 0; b < 8; b++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            send_raw(1'b0, 1'b0, c, 8'h00, ctrl_code(c));
         end
      end

      // Reset asserted mid-line takes effect without a clock edge
      for (int p = 0; p < 5; p++) send_video_model(8'($urandom_range(0, 255)));
      @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1 check_sym("reset_async", tmds_o, 10'h354);
      exp_q.delete();
      vid_q.delete();
      issue = 1'b0;
      model_cnt = 0;
      run_disp = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      de_i = 1'b0;
      guard_i = 1'b0;
      ctrl_i = 2'b10;
      exp_q.push_back(10'h154);
      vid_q.push_back(9'h000);
      issue = 1'b1;
      send_raw(1'b1, 1'b0, 2'b00, 8'h00, 10'h100);

`ifdef TMDS_ENC_TERC4_EN
      for (int a = 0; a < 16; a++) begin
         aux_i = 4'(a);
         island_i = 1'b1;
         send_raw(1'b0, 1'b0, 2'b00, 8'h00, terc4_tbl[a]);
      end
      send_raw(1'b0, 1'b1, 2'b00, 8'h00, 10'h133);
      send_raw(1'b1, 1'b0, 2'b00, 8'h00, 10'h100);
      island_i = 1'b0;
`endif

      send_idle();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
      if (exp_q.size() > 0) check_range("drain_pending", exp_q.size(), 0, 0);
      @(negedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
